// File: rtl/pll_reconf_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | Module   : pll_reconf_ctrl_if                                            |
// | Brief    : Request/status bus and PLLA MDRP bus seen by pll_reconf_ctrl. |
// |            slave  = the reconfiguration controller.                      |
// |            master = its environment (display control + PLL wrapper).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pll_reconf_ctrl_if;
   // request / status side
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_mdiv;
   logic [7:0] cfg_odiv0;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;
   logic       pll_locked;
   // PLL side
   logic       pll_reset;
   logic       pll_lock;
   logic       md_clk;
   logic [1:0] md_opc;
   logic       md_ainc;
   logic [7:0] md_wdi;
   logic [7:0] md_rdo;

   modport slave (
      input  cfg_valid, cfg_mdiv, cfg_odiv0, pll_lock, md_rdo,
      output cfg_ready, busy, done, err, err_code, pll_locked,
             pll_reset, md_clk, md_opc, md_ainc, md_wdi
   );

   modport master (
      output cfg_valid, cfg_mdiv, cfg_odiv0, pll_lock, md_rdo,
      input  cfg_ready, busy, done, err, err_code, pll_locked,
             pll_reset, md_clk, md_opc, md_ainc, md_wdi
   );
endinterface

`default_nettype wire

// File: rtl/pll_reconf_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : pll_reconf_ctrl                                               |
// | Brief    : Retunes the pixel-clock PLL through its MDRP port. Writes     |
// |            MDIV then ODIV0 with the PLL held in reset, reads each one    |
// |            back, releases reset and qualifies lock with a timeout.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module pll_reconf_ctrl #(
   parameter logic [7:0] MDIV_ADDR    = 8'h04,
   parameter logic [7:0] ODIV0_ADDR   = 8'h08,
   parameter logic [1:0] OPC_NOP      = 2'b00,
   parameter logic [1:0] OPC_ADDR     = 2'b11,
   parameter logic [1:0] OPC_WR       = 2'b01,
   parameter logic [1:0] OPC_RD       = 2'b10,
   parameter int         RST_HOLD     = 16,
   parameter int         LOCK_STABLE  = 64,
   parameter int         LOCK_TIMEOUT = 100000
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   pll_reconf_ctrl_if.slave  bus
);

   localparam int HCNT_W = $clog2(RST_HOLD + 1);
   localparam int LCNT_W = $clog2(LOCK_STABLE + 1);
   localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);

   // RST_HOLD..CAP are kept consecutive: md_clk runs only inside that range
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_RST_HOLD  = 4'd1;
   localparam logic [3:0] S_ADDR      = 4'd2;
   localparam logic [3:0] S_WR        = 4'd3;
   localparam logic [3:0] S_RD        = 4'd4;
   localparam logic [3:0] S_CAP       = 4'd5;
   localparam logic [3:0] S_NEXT      = 4'd6;
   localparam logic [3:0] S_REL       = 4'd7;
   localparam logic [3:0] S_WAIT_LOCK = 4'd8;
   localparam logic [3:0] S_FIN       = 4'd9;

   logic [3:0]        state_q, state_d;
   logic              phase_q, phase_d;
   logic              idx_q, idx_d;
   logic [7:0]        mdiv_q, mdiv_d;
   logic [7:0]        odiv0_q, odiv0_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic              lock_meta_q, lock_meta_d;
   logic              lock_sync_q, lock_sync_d;
   logic              pll_reset_q, pll_reset_d;
   logic              pll_locked_q, pll_locked_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              md_clk_q, md_clk_d;
   logic [1:0]        md_opc_q, md_opc_d;
   logic [7:0]        md_wdi_q, md_wdi_d;

   // data written to the register currently being checked in CAP
   logic [7:0] cur_data;
   assign cur_data = idx_q ? odiv0_q : mdiv_q;

   // next-state, counters and MDRP bus values for the coming cycle
   always_comb begin
      state_d      = state_q;
      phase_d      = 1'b0;
      idx_d        = idx_q;
      mdiv_d       = mdiv_q;
      odiv0_d      = odiv0_q;
      hcnt_d       = '0;
      lcnt_d       = lcnt_q;
      tcnt_d       = '0;
      lock_meta_d  = bus.pll_lock;
      lock_sync_d  = lock_meta_q;
      pll_reset_d  = pll_reset_q;
      pll_locked_d = pll_locked_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      err_code_d   = err_code_q;
      md_clk_d     = 1'b0;
      md_opc_d     = OPC_NOP;
      md_wdi_d     = 8'h00;

      case (state_q)
         S_IDLE: begin
            // free-running lock qualifier while no request is in flight
            if (lock_sync_q) begin
               if (lcnt_q != LCNT_W'(LOCK_STABLE))
                  lcnt_d = lcnt_q + 1'b1;
               if (lcnt_q >= LCNT_W'(LOCK_STABLE - 1))
                  pll_locked_d = 1'b1;
            end else begin
               lcnt_d       = '0;
               pll_locked_d = 1'b0;
            end
            if (bus.cfg_valid) begin
               mdiv_d       = bus.cfg_mdiv;
               odiv0_d      = bus.cfg_odiv0;
               idx_d        = 1'b0;
               err_code_d   = 2'd0;
               pll_locked_d = 1'b0;
               lcnt_d       = '0;
               if (bus.cfg_mdiv == 8'h00 || bus.cfg_odiv0 == 8'h00) begin
                  // a zero divider is never legal: reject without touching the PLL
                  err_d      = 1'b1;
                  err_code_d = 2'd1;
               end else begin
                  state_d     = S_RST_HOLD;
                  pll_reset_d = 1'b1;
               end
            end
         end
         S_RST_HOLD: begin
            phase_d = ~phase_q;
            hcnt_d  = hcnt_q + 1'b1;
            if (hcnt_q == HCNT_W'(RST_HOLD - 1)) begin
               state_d = S_ADDR;
               phase_d = 1'b0;
               hcnt_d  = '0;
            end
         end
         S_ADDR, S_WR, S_RD: begin
            phase_d = ~phase_q;
            if (phase_q)
               state_d = state_q + 4'd1;
         end
         S_CAP: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               phase_d = 1'b0;
               if (bus.md_rdo != cur_data) begin
                  // PLL is left in reset so it never runs on a half-written config
                  state_d    = S_IDLE;
                  err_d      = 1'b1;
                  err_code_d = 2'd2;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            if (!idx_q) begin
               idx_d   = 1'b1;
               state_d = S_ADDR;
            end else begin
               state_d     = S_REL;
               pll_reset_d = 1'b0;
            end
         end
         S_REL: begin
            state_d = S_WAIT_LOCK;
            tcnt_d  = tcnt_q + 1'b1;
            lcnt_d  = '0;
         end
         S_WAIT_LOCK: begin
            tcnt_d = tcnt_q + 1'b1;
            lcnt_d = lock_sync_q ? lcnt_q + 1'b1 : '0;
            // lock wins over a timeout landing in the same cycle
            if (lock_sync_q && lcnt_q == LCNT_W'(LOCK_STABLE - 1)) begin
               state_d      = S_FIN;
               pll_locked_d = 1'b1;
               done_d       = 1'b1;
               lcnt_d       = LCNT_W'(LOCK_STABLE);
            end else if (tcnt_q == TCNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d    = S_IDLE;
               err_d      = 1'b1;
               err_code_d = 2'd3;
               lcnt_d     = '0;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // MDRP bus follows the state being entered so it is stable for the whole slot
      if (state_d >= S_RST_HOLD && state_d <= S_CAP)
         md_clk_d = phase_d;
      case (state_d)
         S_ADDR: begin
            md_opc_d = OPC_ADDR;
            md_wdi_d = idx_d ? ODIV0_ADDR : MDIV_ADDR;
         end
         S_WR: begin
            md_opc_d = OPC_WR;
            md_wdi_d = idx_d ? odiv0_q : mdiv_q;
         end
         S_RD:    md_opc_d = OPC_RD;
         default: md_opc_d = OPC_NOP;
      endcase
   end

   // state and output registers; reset clears everything including pll_reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         phase_q      <= 1'b0;
         idx_q        <= 1'b0;
         mdiv_q       <= 8'h00;
         odiv0_q      <= 8'h00;
         hcnt_q       <= '0;
         lcnt_q       <= '0;
         tcnt_q       <= '0;
         lock_meta_q  <= 1'b0;
         lock_sync_q  <= 1'b0;
         pll_reset_q  <= 1'b0;
         pll_locked_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'd0;
         md_clk_q     <= 1'b0;
         md_opc_q     <= OPC_NOP;
         md_wdi_q     <= 8'h00;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         mdiv_q       <= mdiv_d;
         odiv0_q      <= odiv0_d;
         hcnt_q       <= hcnt_d;
         lcnt_q       <= lcnt_d;
         tcnt_q       <= tcnt_d;
         lock_meta_q  <= lock_meta_d;
         lock_sync_q  <= lock_sync_d;
         pll_reset_q  <= pll_reset_d;
         pll_locked_q <= pll_locked_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         md_clk_q     <= md_clk_d;
         md_opc_q     <= md_opc_d;
         md_wdi_q     <= md_wdi_d;
      end
   end

   assign bus.cfg_ready  = (state_q == S_IDLE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.err_code   = err_code_q;
   assign bus.pll_locked = pll_locked_q;
   assign bus.pll_reset  = pll_reset_q;
   assign bus.md_clk     = md_clk_q;
   assign bus.md_opc     = md_opc_q;
   assign bus.md_ainc    = 1'b0;
   assign bus.md_wdi     = md_wdi_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconf_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_pll_reconf_ctrl                                            |
// | Brief    : Directed bench for pll_reconf_ctrl with a behavioural MDRP    |
// |            register file and PLL lock model.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pll_reconf_ctrl;

   localparam int T_TO   = 1000;
   localparam int BUDGET = 3000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pll_reconf_ctrl_if ifc ();

   pll_reconf_ctrl #(.LOCK_TIMEOUT(T_TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- PLL / MDRP model ----------------
   logic [7:0] mem [256];
   logic [7:0] ptr     = 8'h00;
   logic [7:0] rdo_m   = 8'h00;
   logic       corrupt = 1'b0;
   logic       lock_en = 1'b0;
   logic       lock_force = 1'b0;
   logic       lock_model = 1'b0;
   int         lock_cnt = 0;
   int         md_rises = 0;
   int         n_done = 0;
   int         n_err = 0;
   int         n_both = 0;

   assign ifc.md_rdo   = rdo_m;
   assign ifc.pll_lock = lock_force | lock_model;

   // register file sampled on md_clk rising edge
   always @(posedge ifc.md_clk) begin
      md_rises <= md_rises + 1;
      case (ifc.md_opc)
         2'b11: ptr <= ifc.md_wdi;
         2'b01: mem[ptr] <= ifc.md_wdi;
         2'b10: rdo_m <= (corrupt && ptr == 8'h08) ? 8'h22 : mem[ptr];
         default: ;
      endcase
   end

   // lock comes up 200 cycles after reset release when enabled
   always @(posedge clk) begin
      if (ifc.pll_reset) begin
         lock_cnt   <= 0;
         lock_model <= 1'b0;
      end else if (lock_en) begin
         if (lock_cnt == 200) lock_model <= 1'b1;
         else                 lock_cnt   <= lock_cnt + 1;
      end
   end

   // pulse counters sampled away from the active edge
   always @(negedge clk) begin
      if (ifc.done) n_done <= n_done + 1;
      if (ifc.err)  n_err  <= n_err + 1;
      if (ifc.done && ifc.err) n_both <= n_both + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running want=finished");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   // issue one request and wait for done/err; k counts samples after the accept edge
   task automatic run_req(input logic [7:0] m, input logic [7:0] o,
                          output logic got_done, output logic got_err,
                          output int k_end, output int k_rel);
      int  w;
      int  k;
      bit  seen_rst;
      w = 0;
      while (!ifc.cfg_ready && w < 100) begin tick(); w++; end
      ifc.cfg_mdiv  = m;
      ifc.cfg_odiv0 = o;
      ifc.cfg_valid = 1'b1;
      tick();
      ifc.cfg_valid = 1'b0;
      k = 1; seen_rst = 1'b0; k_rel = -1; k_end = -1;
      got_done = 1'b0; got_err = 1'b0;
      while (k <= BUDGET) begin
         if (ifc.pll_reset) seen_rst = 1'b1;
         else if (seen_rst && k_rel < 0) k_rel = k;
         if (ifc.done || ifc.err) begin
            got_done = ifc.done; got_err = ifc.err; k_end = k;
            break;
         end
         tick();
         k++;
      end
      if (k_end < 0) chk("req_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [7:0] mdiv;
      logic [7:0] odiv0;
      bit         corrupt;
      bit         lock_ok;
      bit         exp_done;
      logic [1:0] exp_code;
      bit         exp_reset;
      int         exp_rises;
      int         exp_kend;
      int         exp_rel_lat;
   } vec_t;

   vec_t vecs [6];
   logic [1:0] slot_opc [8];
   logic [7:0] slot_wdi [8];

   initial begin
      logic       gd, ge;
      int         ke, kr, r0, d0, e0, s;
      logic [11:0] exp_bus;

      vecs[0] = '{8'd14, 8'd35, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 16, -1, -1};
      vecs[1] = '{8'd14, 8'd0,  1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 0,  1,  -1};
      vecs[2] = '{8'd0,  8'd35, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 0,  1,  -1};
      vecs[3] = '{8'd14, 8'd35, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 16, 34, -1};
      vecs[4] = '{8'd20, 8'd10, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 16, -1, -1};
      vecs[5] = '{8'd5,  8'd7,  1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 16, -1, T_TO};

      slot_opc = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
      slot_wdi = '{8'h04, 8'h0E, 8'h00, 8'h00, 8'h08, 8'h23, 8'h00, 8'h00};

      ifc.cfg_valid = 1'b0;
      ifc.cfg_mdiv  = 8'h00;
      ifc.cfg_odiv0 = 8'h00;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick(); tick();
      // {cfg_ready,busy,done,err,err_code,pll_locked,pll_reset,md_clk,md_opc} + md_wdi
      chk("reset_ctrl", {ifc.cfg_ready, ifc.busy, ifc.done, ifc.err, ifc.err_code,
                         ifc.pll_locked, ifc.pll_reset, ifc.md_clk, ifc.md_opc, ifc.md_ainc}, 12'h800);
      chk("reset_wdi", ifc.md_wdi, 8'h00);
      rst_n = 1'b1;
      tick();

      // lock qualification: 2 sync + 64 stable cycles
      lock_force = 1'b1;
      repeat (65) tick();
      chk("lock_early", ifc.pll_locked, 1'b0);
      tick();
      chk("lock_at_66", ifc.pll_locked, 1'b1);
      chk("ready_idle", ifc.cfg_ready, 1'b1);
      lock_force = 1'b0;
      repeat (3) tick();
      chk("lock_drop", ifc.pll_locked, 1'b0);

      // cycle-exact MDRP waveform for mdiv=14, odiv0=35
      lock_en = 1'b1;
      d0 = n_done;
      ifc.cfg_mdiv = 8'd14; ifc.cfg_odiv0 = 8'd35; ifc.cfg_valid = 1'b1;
      tick();
      ifc.cfg_valid = 1'b0;
      for (int k = 1; k <= 35; k++) begin
         // {md_clk, md_opc, md_wdi, pll_reset}
         if (k <= 16)                 exp_bus = {(k % 2 == 0) ? 1'b1 : 1'b0, 2'b00, 8'h00, 1'b1};
         else if (k <= 24) begin s = (k - 17) / 2;
                                      exp_bus = {((k - 17) % 2 == 1) ? 1'b1 : 1'b0, slot_opc[s], slot_wdi[s], 1'b1}; end
         else if (k == 25)            exp_bus = {1'b0, 2'b00, 8'h00, 1'b1};
         else if (k <= 33) begin s = 4 + (k - 26) / 2;
                                      exp_bus = {((k - 26) % 2 == 1) ? 1'b1 : 1'b0, slot_opc[s], slot_wdi[s], 1'b1}; end
         else if (k == 34)            exp_bus = {1'b0, 2'b00, 8'h00, 1'b1};
         else                         exp_bus = {1'b0, 2'b00, 8'h00, 1'b0};
         chk($sformatf("mdrp_cycle_%0d", k), {ifc.md_clk, ifc.md_opc, ifc.md_wdi, ifc.pll_reset}, exp_bus);
         tick();
      end
      s = 0;
      while (!ifc.cfg_ready && s < BUDGET) begin tick(); s++; end
      repeat (5) tick();
      chk("seq_done_once", n_done - d0, 1);
      chk("seq_err_code", ifc.err_code, 2'd0);
      chk("seq_locked", ifc.pll_locked, 1'b1);

      // table-driven requests
      for (int i = 0; i < 6; i++) begin
         corrupt = vecs[i].corrupt;
         lock_en = vecs[i].lock_ok;
         r0 = md_rises;
         run_req(vecs[i].mdiv, vecs[i].odiv0, gd, ge, ke, kr);
         chk($sformatf("v%0d_done", i), gd, vecs[i].exp_done);
         chk($sformatf("v%0d_err", i), ge, !vecs[i].exp_done);
         chk($sformatf("v%0d_code", i), ifc.err_code, vecs[i].exp_code);
         chk($sformatf("v%0d_locked", i), ifc.pll_locked, vecs[i].exp_done);
         chk($sformatf("v%0d_rises", i), md_rises - r0, vecs[i].exp_rises);
         if (vecs[i].exp_kend >= 0)
            chk($sformatf("v%0d_latency", i), ke, vecs[i].exp_kend);
         if (vecs[i].exp_rel_lat >= 0)
            chk($sformatf("v%0d_rel_to_err", i), ke - kr, vecs[i].exp_rel_lat);
         tick();
         chk($sformatf("v%0d_pll_reset", i), ifc.pll_reset, vecs[i].exp_reset);
         chk($sformatf("v%0d_pulse_len", i), {ifc.done, ifc.err}, 2'b00);
      end
      corrupt = 1'b0;

      // asynchronous reset during the MDIV write slot
      lock_en = 1'b1;
      ifc.cfg_mdiv = 8'd14; ifc.cfg_odiv0 = 8'd35; ifc.cfg_valid = 1'b1;
      tick();
      ifc.cfg_valid = 1'b0;
      repeat (18) tick();
      chk("rst_in_wr_slot", {ifc.md_opc, ifc.md_wdi, ifc.pll_reset}, {2'b01, 8'h0E, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("rst_async_ctrl", {ifc.cfg_ready, ifc.busy, ifc.done, ifc.err, ifc.err_code,
                             ifc.pll_locked, ifc.pll_reset, ifc.md_clk, ifc.md_opc, ifc.md_ainc}, 12'h800);
      chk("rst_async_wdi", ifc.md_wdi, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();

      // cfg_valid while busy is ignored
      d0 = n_done; e0 = n_err;
      ifc.cfg_mdiv = 8'd14; ifc.cfg_odiv0 = 8'd35; ifc.cfg_valid = 1'b1;
      tick();
      ifc.cfg_valid = 1'b0;
      s = 1;
      while (!ifc.cfg_ready && s < BUDGET) begin
         if (s == 5 || s == 30) begin
            ifc.cfg_mdiv = 8'd0; ifc.cfg_odiv0 = 8'd0; ifc.cfg_valid = 1'b1;
         end else begin
            ifc.cfg_valid = 1'b0;
         end
         tick();
         s++;
      end
      ifc.cfg_valid = 1'b0;
      chk("busy_finished", s < BUDGET, 1'b1);
      repeat (20) tick();
      chk("busy_one_done", n_done - d0, 1);
      chk("busy_no_err", n_err - e0, 0);
      chk("busy_err_code", ifc.err_code, 2'd0);
      chk("done_err_exclusive", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
